// File: rtl/zx_sound_bus_ctrl.sv
// ZX-Spectrum sound-bus controller: registered Z80 decode for up to four YM/AY chips,
// a Covox DAC latch, the #FE beeper/tape-out bits and a free-running YM clock divider.
module zx_sound_bus_ctrl #(
   parameter int         NUM_CHIPS  = 2,
   parameter int         YM_DIV     = 2,
   parameter logic [7:0] COVOX_PORT = 8'hFB
) (
   input  logic                 cpu_clock,
   input  logic                 reset,
   input  logic [15:0]          addr,
   input  logic [7:0]           data_in,
   input  logic                 iorq,
   input  logic                 wr,
   input  logic                 rd,
   input  logic                 m1,
   input  logic                 dos,
   output logic                 bc1,
   output logic                 bdir,
   output logic [NUM_CHIPS-1:0] ym_sel,
   output logic                 ym_clock,
   output logic                 beeper,
   output logic                 tapeout,
   output logic [7:0]           covox_data,
   output logic                 covox_strobe,
   output logic                 ioge
);

   localparam int HALF = YM_DIV / 2;
   localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      HOLD   = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    mode_q, mode_d;
   logic          acc_rd_q, acc_rd_d;
   logic [1:0]    sel_q, sel_d;
   logic          iorq_q, wr_q, rd_q, m1_q;
   logic          wr_prev_q, rd_prev_q;
   logic          beeper_q, tapeout_q;
   logic [7:0]    covox_data_q;
   logic          covox_strobe_q;
   logic [CW-1:0] div_q, div_d;
   logic          ym_clk_q, ym_clk_d;

   logic          wr_ev_s, rd_ev_s, qual_s;
   logic          ym_lo_s, aport_s, dport_s;
   logic [7:0]    sel_inv_s;
   logic          sel_hit_s;
   logic          aw_s, ar_s, dw_s;
   logic          addr_unused_s;

   assign addr_unused_s = ^addr[13:8];

   // Bus decode from the registered strobes; data_in = 8'hFF - k is the same as ~data_in = k.
   always_comb begin
      wr_ev_s   = ~iorq_q & ~wr_q & wr_prev_q;
      rd_ev_s   = ~iorq_q & ~rd_q & rd_prev_q;
      qual_s    = m1_q & dos;
      ym_lo_s   = (addr[7:0] == 8'hFD);
      aport_s   = ym_lo_s & (addr[15:14] == 2'b11);
      dport_s   = ym_lo_s & (addr[15:14] == 2'b10);
      sel_inv_s = ~data_in;
      sel_hit_s = (sel_inv_s[7:2] == 6'd0) && ({1'b0, sel_inv_s[1:0]} < 3'(NUM_CHIPS));
      aw_s      = wr_ev_s & qual_s & aport_s;
      ar_s      = rd_ev_s & qual_s & aport_s;
      dw_s      = wr_ev_s & qual_s & dport_s;
   end

   // State register plus the access mode and chip select it carries.
   always_ff @(posedge cpu_clock) begin
      if (reset) begin
         state_q  <= IDLE;
         mode_q   <= 2'b00;
         acc_rd_q <= 1'b0;
         sel_q    <= 2'd0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         acc_rd_q <= acc_rd_d;
         sel_q    <= sel_d;
      end
   end

   // Next-state logic; mode_d holds {bc1, bdir} for the access about to start.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      acc_rd_d = acc_rd_q;
      sel_d    = sel_q;
      case (state_q)
         IDLE: begin
            if (aw_s) begin
               state_d  = ACCESS;
               acc_rd_d = 1'b0;
               if (sel_hit_s) begin
                  mode_d = 2'b00;
                  sel_d  = sel_inv_s[1:0];
               end else begin
                  mode_d = 2'b11;
               end
            end else if (ar_s) begin
               state_d  = ACCESS;
               mode_d   = 2'b10;
               acc_rd_d = 1'b1;
            end else if (dw_s) begin
               state_d  = ACCESS;
               mode_d   = 2'b01;
               acc_rd_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            if (iorq_q | (acc_rd_q ? rd_q : wr_q)) begin
               state_d = HOLD;
            end else begin
               state_d = ACCESS;
            end
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from registered state only, so they change cleanly on the clock edge.
   always_comb begin
      bc1    = (state_q == ACCESS) & mode_q[1];
      bdir   = (state_q == ACCESS) & mode_q[0];
      ioge   = (state_q != IDLE);
      ym_sel = {NUM_CHIPS{1'b1}};
      for (int i = 0; i < NUM_CHIPS; i++) begin
         ym_sel[i] = (sel_q != 2'(i));
      end
   end

   // Input strobe register and previous-strobe copies for edge detection.
   always_ff @(posedge cpu_clock) begin
      if (reset) begin
         iorq_q    <= 1'b1;
         wr_q      <= 1'b1;
         rd_q      <= 1'b1;
         m1_q      <= 1'b1;
         wr_prev_q <= 1'b1;
         rd_prev_q <= 1'b1;
      end else begin
         iorq_q    <= iorq;
         wr_q      <= wr;
         rd_q      <= rd;
         m1_q      <= m1;
         wr_prev_q <= wr_q;
         rd_prev_q <= rd_q;
      end
   end

   // Beeper/tape-out latch (decoded without dos) and the Covox latch with its strobe.
   always_ff @(posedge cpu_clock) begin
      if (reset) begin
         beeper_q       <= 1'b0;
         tapeout_q      <= 1'b0;
         covox_data_q   <= 8'h00;
         covox_strobe_q <= 1'b0;
      end else begin
         if (wr_ev_s & m1_q & ~addr[0]) begin
            beeper_q  <= data_in[4];
            tapeout_q <= data_in[3];
         end
         if (wr_ev_s & qual_s & (addr[7:0] == COVOX_PORT)) begin
            covox_data_q   <= data_in;
            covox_strobe_q <= 1'b1;
         end else begin
            covox_strobe_q <= 1'b0;
         end
      end
   end

   assign beeper       = beeper_q;
   assign tapeout      = tapeout_q;
   assign covox_data   = covox_data_q;
   assign covox_strobe = covox_strobe_q;

   // Divider next state: count 0..HALF-1 and toggle the YM clock on wrap.
   always_comb begin
      if (div_q == CW'(HALF - 1)) begin
         div_d    = {CW{1'b0}};
         ym_clk_d = ~ym_clk_q;
      end else begin
         div_d    = div_q + CW'(1);
         ym_clk_d = ym_clk_q;
      end
   end

   // Free-running divider register.
   always_ff @(posedge cpu_clock) begin
      if (reset) begin
         div_q    <= {CW{1'b0}};
         ym_clk_q <= 1'b0;
      end else begin
         div_q    <= div_d;
         ym_clk_q <= ym_clk_d;
      end
   end

   assign ym_clock = ym_clk_q;

endmodule
